// File: rtl/ipf_res_drain.sv
// ---------------------------------------------------------------------------
// ipf_res_drain
//
// Purpose:
//   Sits downstream of the IPF convolution engine. Each IPF result is one
//   RES_W-bit word (128 lanes x 9 bits by default), strobed for a single
//   cycle on res_valid. Results are held in a small circular buffer. Each
//   one is then serialized into BEATS beats of OUT_W bits, least-significant
//   slice first, and each beat carries a running word address. Beats are
//   drained to the result-memory write port under a valid/ready handshake.
//   IPF cannot be stalled, so a result that arrives while the buffer is full
//   is dropped and counted.
//
//   RES_W must equal BEATS*OUT_W, and DEPTH must be a power of two >= 2.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous reset, active low (0 = reset)
//   res_valid  in   IPF result strobe, one cycle per result
//   res        in   IPF result word, sampled when res_valid=1
//   finish     in   IPF completion (level or pulse), latched internally
//   o_valid    out  beat valid
//   o_ready    in   memory accepts the current beat
//   o_data     out  beat data
//   o_addr     out  beat word address, free-running across results
//   o_last     out  final beat of a result
//   overflow   out  sticky flag: at least one result was dropped
//   drop_cnt   out  number of dropped results, saturates at 255
//   done       out  finish seen and every accepted result drained
// ---------------------------------------------------------------------------
module ipf_res_drain #(
  parameter int RES_W   = 1152,
  parameter int OUT_W   = 64,
  parameter int BEATS   = 18,
  parameter int DEPTH   = 2,
  parameter int A_Width = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               res_valid,
  input  logic [RES_W-1:0]   res,
  input  logic               finish,
  output logic               o_valid,
  input  logic               o_ready,
  output logic [OUT_W-1:0]   o_data,
  output logic [A_Width-1:0] o_addr,
  output logic               o_last,
  output logic               overflow,
  output logic [7:0]         drop_cnt,
  output logic               done
);

  // -------------------------------------------------------------------------
  // Derived sizes
  // -------------------------------------------------------------------------
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  // The slice table is padded to a power of two so that every value of
  // the beat counter selects a defined entry.
  localparam int SLOTS  = 1 << BEAT_W;

  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
  localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);
  localparam logic [A_Width-1:0] ADDR_ONE = A_Width'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t              state_q,    state_d;
  logic [PTR_W-1:0]    wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q,   rd_ptr_d;
  logic [CNT_W-1:0]    count_q,    count_d;
  logic [BEAT_W-1:0]   beat_q,     beat_d;
  logic [A_Width-1:0]  addr_q,     addr_d;
  logic                finish_q,   finish_d;
  logic                overflow_q, overflow_d;
  logic [7:0]          drop_cnt_q, drop_cnt_d;

  // Result storage. Contents carry no meaning while count_q says the slot
  // is free, so the array is not reset; emptiness comes from count_q alone.
  logic [RES_W-1:0]    res_mem [DEPTH];

  // -------------------------------------------------------------------------
  // Handshake and buffer control
  // -------------------------------------------------------------------------
  logic beat_fire;   // current beat is accepted at this edge
  logic last_fire;   // accepted beat is the final beat of a result (pop)
  logic push;        // incoming result is written into the buffer
  logic drop;        // incoming result is discarded

  assign beat_fire = (state_q == ST_SEND) && o_ready;
  assign last_fire = beat_fire && (beat_q == LAST_BEAT);

  // The slot freed by an accepted final beat is reusable in the same cycle,
  // so a full buffer still takes a result that coincides with that beat.
  // Once DONE is reached the stream is closed and everything is dropped.
  assign push = res_valid && (state_q != ST_DONE) &&
                ((count_q != CNT_FULL) || last_fire);
  assign drop = res_valid && !push;

  // -------------------------------------------------------------------------
  // Beat selection: slice the head entry into OUT_W-wide pieces
  // -------------------------------------------------------------------------
  logic [RES_W-1:0] rd_entry;
  logic [OUT_W-1:0] beat_slices [SLOTS];

  assign rd_entry = res_mem[rd_ptr_q];

  for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slice
    if (gi < BEATS) begin : g_used
      assign beat_slices[gi] = rd_entry[gi*OUT_W +: OUT_W];
    end else begin : g_pad
      assign beat_slices[gi] = '0;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    beat_d     = beat_q;
    addr_d     = addr_q;
    finish_d   = finish_q | finish;
    overflow_d = overflow_q | drop;
    drop_cnt_d = drop_cnt_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end

    if (drop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end

    // Occupancy after this edge; a simultaneous push and pop cancel out.
    unique case ({push, last_fire})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    unique case (state_q)
      ST_IDLE: begin
        if (count_q != '0) begin
          state_d = ST_SEND;
          beat_d  = '0;
        end else if (finish_q && !res_valid) begin
          // A result arriving in the same cycle is still taken and
          // drained before completion is reported.
          state_d = ST_DONE;
        end
      end

      ST_SEND: begin
        if (beat_fire) begin
          addr_d = addr_q + ADDR_ONE;
          if (last_fire) begin
            beat_d   = '0;
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            // Go straight on to the next entry when one is waiting, so
            // back-to-back results leave no gap on the output.
            state_d  = (count_d != '0) ? ST_SEND : ST_IDLE;
          end else begin
            beat_d = beat_q + BEAT_ONE;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_DONE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      beat_q     <= '0;
      addr_q     <= '0;
      finish_q   <= 1'b0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      beat_q     <= beat_d;
      addr_q     <= addr_d;
      finish_q   <= finish_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      res_mem[wr_ptr_q] <= res;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  // Beat outputs are decoded from registered state only, so they hold
  // steady for as long as the memory stalls, and they drop to zero as soon
  // as reset forces the FSM back to IDLE.
  assign o_valid  = (state_q == ST_SEND);
  assign o_last   = o_valid && (beat_q == LAST_BEAT);
  assign o_data   = o_valid ? beat_slices[beat_q] : '0;
  assign o_addr   = addr_q;
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;
  assign done     = (state_q == ST_DONE);

endmodule
